input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Parametrised, multi-channel front end for the Tamagotchi's push-buttons and binary sensor outputs (photo, ultrasound).
- Replaces the per-signal debounce and hold-detect instances with one block that handles N_CH channels.
- Per channel: polarity normalisation, 2-FF synchronisation, stable-time debounce, press/release pulses, and long-hold detection.
- Outputs feed the game FSM directly.

Parameters:
N_CH, 4, number of independent input channels (1..16)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (>=2)
HOLD_CYCLES, 50000000, cycles level must stay high before hold asserts (>=2)
REPEAT_CYCLES, 12500000, auto-repeat period while held (used only with INPUT_COND_REPEAT_EN)
ACTIVE_LOW, {N_CH{1'b0}}, per-channel mask; bit=1 inverts raw input (FPGA push-buttons are active-low)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high; clears all state
raw_in  in  N_CH  raw asynchronous inputs (buttons/sensors)
level  out  N_CH  debounced, polarity-normalised level (1 = active)
press  out  N_CH  one-cycle pulse on debounced activation (and on repeats, see Optional Feature)
release_p  out  N_CH  one-cycle pulse on debounced deactivation
hold  out  N_CH  high while channel held >= HOLD_CYCLES; clears with level
any_press  out  1  OR of press

Behaviour:
- Reset: clk, one clock; reset asynchronous active-high on rst. All sync flops, counters, level, press, release_p, hold and any_press go to 0 immediately on rst.
- Stage 1: n = raw_in ^ ACTIVE_LOW (combinational).
- Stage 2: two-flop synchroniser per channel → s. Sync flops reset to 0 (= inactive).
- Debounce (per channel):
  - db_cnt has width $clog2(DEBOUNCE_CYCLES).
  - On each edge with s == level: db_cnt <= 0.
  - On each edge with s != level: if db_cnt == DEBOUNCE_CYCLES-1, then level <= s and db_cnt <= 0; else db_cnt++.
  - Latency: edge 1 is the first edge that samples the new raw value. level changes on edge DEBOUNCE_CYCLES+2.
  - Any bounce back to the old value before then restarts the count at 0.
- Pulses:
  - press <= 1 on the same edge level goes 0→1; release_p <= 1 on the edge level goes 1→0.
  - Both are exactly one cycle wide; otherwise 0.
- Hold counter:
  - hold_cnt has width $clog2(HOLD_CYCLES) and is held at 0 while level==0.
  - While level==1 and hold==0: if hold_cnt == HOLD_CYCLES-1, then hold <= 1; else hold_cnt++.
  - hold rises HOLD_CYCLES edges after level rises, then saturates (counter frozen).
  - hold <= 0 and hold_cnt <= 0 on the same edge level falls.
- Channels are fully independent. Simultaneous events on multiple channels each produce their own pulses in the same cycle.
- Per-channel state machine, encoded implicitly in {level, hold, db_cnt != 0}: IDLE → ARMING (db counting) → ACTIVE → HELD → RELEASING (db counting) → IDLE. ARMING falls back to IDLE, and RELEASING to ACTIVE/HELD, on a bounce.
- Reset mid-operation: all outputs drop to 0. If an input is still active after rst deasserts, the channel re-debounces and emits a fresh press.
- any_press = |press (combinational from registered press).

Optional Feature:
- Macro: INPUT_COND_REPEAT_EN.
- Defined:
  - Per-channel rep_cnt (width $clog2(REPEAT_CYCLES)) runs while hold==1.
  - Every REPEAT_CYCLES cycles after hold rises, press pulses one cycle (first repeat REPEAT_CYCLES edges after hold rise).
  - rep_cnt clears when hold falls.
  - release_p is unaffected.
- Undefined: no repeat logic is synthesised; press fires only on the level 0→1 edge; REPEAT_CYCLES is ignored.

Test Plan:
All scenarios use N_CH=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW=3'b011.
1. Clean press, raw_in[0] 1→0 sampled at edge 1 and held → level[0]=1 and press[0]=1 at edge 6; press[0]=0 at edge 7; any_press=1 only at edge 6.
2. Glitch, raw_in[2] high for 3 cycles then low → level[2], press[2] stay 0; a bounce 0→1→0 mid-debounce restarts db_cnt.
3. Long hold, channel 0 active for 20 cycles after level rise → hold[0] rises at 10 edges after level rise. On release: level/hold clear at debounce+2 edges, with a single release_p[0] pulse.
4. Simultaneous: raw_in=3'b100 from 3'b011 at the same edge → level=3'b111, press=3'b111 together at edge 6.
5. rst asserted while channel 1 HELD → all outputs 0 asynchronously. With input still active after release, press[1] reasserts at edge 6 after deassertion.
6. With INPUT_COND_REPEAT_EN: hold 20 cycles past hold rise → press[0] pulses at hold+5, +10, +15, +20. Without the macro: no press after the first.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner
//   Multi-channel front end for push-buttons and binary sensor outputs.
//   Each channel is handled independently:
//     polarity normalisation -> 2-FF synchroniser -> stable-time debounce
//     -> press / release pulses -> long-hold detection.
//   The per-channel state (IDLE / ARMING / ACTIVE / HELD / RELEASING) is
//   implicit in {level, hold, db_cnt != 0}. No separate state register exists.
//
// Optional feature (macro INPUT_COND_REPEAT_EN):
//   While hold is asserted, press re-pulses every REPEAT_CYCLES cycles.
//   The first repeat comes REPEAT_CYCLES edges after hold rises. Without the
//   macro, no repeat logic is built and REPEAT_CYCLES only takes part in the
//   parameter sanity check.
//
// Parameters:
//   N_CH            number of channels (1..16)
//   DEBOUNCE_CYCLES consecutive stable cycles before level changes (>=2)
//   HOLD_CYCLES     cycles level must stay high before hold asserts (>=2)
//   REPEAT_CYCLES   auto-repeat period while held (repeat build only)
//   ACTIVE_LOW      per-channel mask; a 1 bit inverts that raw input
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, clears all state
//   raw_in     raw asynchronous inputs
//   level      debounced, polarity-normalised level (1 = active)
//   press      one-cycle pulse on debounced activation (and on repeats)
//   release_p  one-cycle pulse on debounced deactivation
//   hold       high while held for >= HOLD_CYCLES; clears with level
//   any_press  OR of press
module input_conditioner #(
  parameter int unsigned     N_CH            = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     HOLD_CYCLES     = 50000000,
  parameter int unsigned     REPEAT_CYCLES   = 12500000,
  parameter logic [N_CH-1:0] ACTIVE_LOW      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] hold,
  output logic            any_press
);

  localparam int unsigned DB_W   = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = ($clog2(HOLD_CYCLES) < 1) ? 1 : $clog2(HOLD_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

`ifdef INPUT_COND_REPEAT_EN
  localparam int unsigned      REP_W    = ($clog2(REPEAT_CYCLES) < 1) ? 1 : $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  if ((N_CH < 1) || (N_CH > 16) || (DEBOUNCE_CYCLES < 2) ||
      (HOLD_CYCLES < 2) || (REPEAT_CYCLES < 1)) begin : g_param_check
    $error("input_conditioner: parameter out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]        sync_q;
    logic              s;
    logic              lvl_q;
    logic [DB_W-1:0]   db_cnt;
    logic              hold_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              press_q;
    logic              rel_q;
    logic              db_done;
    logic              rise;
    logic              fall;
    logic              rep_fire;

    assign s = sync_q[1];

    // The debounce count completes on this edge, so level takes the value of s.
    assign db_done = (s != lvl_q) && (db_cnt == DB_LAST);
    assign rise    = db_done &  s;
    assign fall    = db_done & ~s;

`ifdef INPUT_COND_REPEAT_EN
    logic [REP_W-1:0] rep_cnt;

    // A repeat that lands on the release edge is dropped; the release wins.
    assign rep_fire = hold_q && !fall && (rep_cnt == REP_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt <= '0;
      end else if (!hold_q || fall) begin
        rep_cnt <= '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q   <= '0;
        lvl_q    <= 1'b0;
        db_cnt   <= '0;
        hold_q   <= 1'b0;
        hold_cnt <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], raw_in[i] ^ ACTIVE_LOW[i]};

        if (s == lvl_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          lvl_q  <= s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end

        // The counter runs only while level is high. It freezes once hold is
        // set and clears on the same edge that level falls.
        if (!lvl_q || fall) begin
          hold_q   <= 1'b0;
          hold_cnt <= '0;
        end else if (!hold_q) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        press_q <= rise | rep_fire;
        rel_q   <= fall;
      end
    end

    assign level[i]     = lvl_q;
    assign press[i]     = press_q;
    assign release_p[i] = rel_q;
    assign hold[i]      = hold_q;
  end

  assign any_press = |press;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] raw_in;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] release_p;
  logic [2:0] hold;
  logic       any_press;

  input_conditioner #(
    .N_CH            (3),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (5),
    .ACTIVE_LOW      (3'b011)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level     (level),
    .press     (press),
    .release_p (release_p),
    .hold      (hold),
    .any_press (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges seen since time 0.
  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // sel: 0 level, 1 press, 2 release_p, 3 hold, 4 any_press
  typedef struct {
    int unsigned at;
    int unsigned sel;
    bit          async_e;
    logic [2:0]  val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   drain  = 0;
  event sample_ev;

  function automatic logic [2:0] obs_of(int unsigned sel);
    case (sel)
      0:       return level;
      1:       return press;
      2:       return release_p;
      3:       return hold;
      default: return {2'b00, any_press};
    endcase
  endfunction

  task automatic exp_v(int unsigned at, int unsigned sel, logic [2:0] val, string tag);
    exp_t e;
    e.at = at; e.sel = sel; e.async_e = 1'b0; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_async0(string tag);
    exp_t e;
    for (int unsigned k = 0; k < 5; k++) begin
      e.at = 0; e.sel = k; e.async_e = 1'b1; e.val = 3'b000; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Scoreboard checker. It wakes on each negedge, or on sample_ev for the
  // asynchronous and drain checks.
  always begin
    logic [2:0] o;
    @(negedge clk or sample_ev);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].async_e || (sb[i].at == edge_n)) begin
        o = obs_of(sb[i].sel);
        checks++;
        assert (o === sb[i].val) else begin
          errors++;
          $error("FAIL %s sel=%0d edge=%0d observed=%b expected=%b",
                 sb[i].tag, sb[i].sel, edge_n, o, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (drain) begin
      checks++;
      assert (sb.size() == 0) else begin
        errors++;
        $error("FAIL sb_empty observed=%0d expected=0", sb.size());
      end
    end
  end

  task automatic go_to(int unsigned e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int unsigned k = 0; k < 5; k++) exp_v(edge_n + 1, k, 3'b000, tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int unsigned e0, hr, rel_at, fall, a, f, r;
  logic [2:0]  pexp;

  initial begin
    rst    = 1'b1;
    raw_in = 3'b011;   // all channels inactive with ACTIVE_LOW = 011

    do_reset("reset_state");

    // Clean press on ch0, long hold, release
    @(negedge clk);
    e0 = edge_n;
    raw_in = 3'b010;
    exp_v(e0 + 5, 0, 3'b000, "s1_level_early");
    exp_v(e0 + 6, 0, 3'b001, "s1_level_rise");
    exp_v(e0 + 5, 1, 3'b000, "s1_press_early");
    exp_v(e0 + 6, 1, 3'b001, "s1_press");
    exp_v(e0 + 7, 1, 3'b000, "s1_press_1cyc");
    exp_v(e0 + 5, 4, 3'b000, "s1_any_early");
    exp_v(e0 + 6, 4, 3'b001, "s1_any");
    exp_v(e0 + 7, 4, 3'b000, "s1_any_after");
    exp_v(e0 + 6, 2, 3'b000, "s1_no_release");
    hr = e0 + 16;
    exp_v(hr - 1, 3, 3'b000, "s3_hold_early");
    exp_v(hr,     3, 3'b001, "s3_hold_rise");
    rel_at = e0 + 36;
    fall   = rel_at + 6;
    for (int unsigned e = e0 + 8; e <= fall + 3; e++) begin
      pexp = 3'b000;
`ifdef INPUT_COND_REPEAT_EN
      if ((e >= hr + 5) && (e < fall) && (((e - hr) % 5) == 0)) pexp = 3'b001;
`endif
      exp_v(e, 1, pexp, "s6_press_repeat");
    end
    exp_v(fall - 1, 0, 3'b001, "s3_level_before_fall");
    exp_v(fall,     0, 3'b000, "s3_level_fall");
    exp_v(fall - 1, 3, 3'b001, "s3_hold_before_fall");
    exp_v(fall,     3, 3'b000, "s3_hold_fall");
    exp_v(fall - 1, 2, 3'b000, "s3_release_early");
    exp_v(fall,     2, 3'b001, "s3_release");
    exp_v(fall + 1, 2, 3'b000, "s3_release_1cyc");
    go_to(rel_at);
    raw_in = 3'b011;
    go_to(fall + 4);

    // Glitch on ch2: three cycles active, never reaches level
    @(negedge clk);
    a = edge_n;
    raw_in = 3'b111;
    for (int unsigned e = a + 1; e <= a + 8; e++) begin
      exp_v(e, 0, 3'b000, "s2_glitch_level");
      exp_v(e, 1, 3'b000, "s2_glitch_press");
    end
    go_to(a + 3);
    raw_in = 3'b011;
    go_to(a + 10);

    // Bounce 1->0->1 mid-debounce restarts the count
    a = edge_n;
    raw_in = 3'b111;
    exp_v(a + 9,  0, 3'b000, "s2_bounce_level_early");
    exp_v(a + 10, 0, 3'b100, "s2_bounce_level");
    exp_v(a + 9,  1, 3'b000, "s2_bounce_press_early");
    exp_v(a + 10, 1, 3'b100, "s2_bounce_press");
    exp_v(a + 11, 1, 3'b000, "s2_bounce_press_1cyc");
    go_to(a + 3);
    raw_in = 3'b011;
    go_to(a + 4);
    raw_in = 3'b111;
    go_to(a + 12);
    raw_in = 3'b011;
    f = edge_n + 6;
    exp_v(f, 2, 3'b100, "s2_release");
    exp_v(f, 3, 3'b000, "s2_no_hold");
    go_to(f + 2);

    // Simultaneous activation on all channels
    do_reset("reset_s4");
    @(negedge clk);
    e0 = edge_n;
    raw_in = 3'b100;
    exp_v(e0 + 5, 0, 3'b000, "s4_level_early");
    exp_v(e0 + 6, 0, 3'b111, "s4_level");
    exp_v(e0 + 6, 1, 3'b111, "s4_press");
    exp_v(e0 + 7, 1, 3'b000, "s4_press_1cyc");
    exp_v(e0 + 6, 4, 3'b001, "s4_any");
    go_to(e0 + 8);
    raw_in = 3'b011;
    f = edge_n + 6;
    exp_v(f, 2, 3'b111, "s4_release");
    exp_v(f, 0, 3'b000, "s4_level_fall");
    go_to(f + 2);

    // Async reset while ch1 is HELD, then re-debounce
    do_reset("reset_s5");
    @(negedge clk);
    e0 = edge_n;
    raw_in = 3'b001;
    exp_v(e0 + 16, 0, 3'b010, "s5_level");
    exp_v(e0 + 16, 3, 3'b010, "s5_hold");
    go_to(e0 + 18);
    #3;
    rst = 1'b1;
    #1;
    exp_async0("s5_async_clear");
    -> sample_ev;
    @(negedge clk);
    rst = 1'b0;
    r = edge_n;
    exp_v(r + 5, 0, 3'b000, "s5_relevel_early");
    exp_v(r + 6, 0, 3'b010, "s5_relevel");
    exp_v(r + 5, 1, 3'b000, "s5_repress_early");
    exp_v(r + 6, 1, 3'b010, "s5_repress");
    exp_v(r + 7, 1, 3'b000, "s5_repress_1cyc");
    go_to(r + 8);
    raw_in = 3'b011;
    go_to(edge_n + 8);

    @(negedge clk);
    #2;
    drain = 1'b1;
    -> sample_ev;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
